// File: rtl/axi_mux_aw_w_scheduler_if.sv
// Handshake bundle between the AXI mux slave ports and the shared master port.
// The master modport is the scheduler's view; the slave modport is the environment's view.
interface axi_mux_aw_w_scheduler_if #(
    parameter int NoSlvPorts = 4
);
    localparam int IdxWidth = $clog2(NoSlvPorts);

    logic [NoSlvPorts-1:0] slv_aw_valid_i;
    logic [NoSlvPorts-1:0] slv_aw_ready_o;
    logic [NoSlvPorts-1:0] slv_w_valid_i;
    logic [NoSlvPorts-1:0] slv_w_last_i;
    logic [NoSlvPorts-1:0] slv_w_ready_o;
    logic                  mst_aw_valid_o;
    logic                  mst_aw_ready_i;
    logic [IdxWidth-1:0]   mst_aw_sel_o;
    logic                  mst_w_valid_o;
    logic                  mst_w_ready_i;
    logic [IdxWidth-1:0]   mst_w_sel_o;

    modport master (
        input  slv_aw_valid_i, slv_w_valid_i, slv_w_last_i, mst_aw_ready_i, mst_w_ready_i,
        output slv_aw_ready_o, slv_w_ready_o, mst_aw_valid_o, mst_aw_sel_o, mst_w_valid_o, mst_w_sel_o
    );

    modport slave (
        output slv_aw_valid_i, slv_w_valid_i, slv_w_last_i, mst_aw_ready_i, mst_w_ready_i,
        input  slv_aw_ready_o, slv_w_ready_o, mst_aw_valid_o, mst_aw_sel_o, mst_w_valid_o, mst_w_sel_o
    );
endinterface

// File: rtl/axi_mux_aw_w_scheduler.sv
// Round-robin AW arbiter with a W-order FIFO that steers W beats in AW acceptance order.
// Define AXI_MUX_W_FALLTHROUGH_EN to forward W in the same cycle as an AW accepted into an empty FIFO.
module axi_mux_aw_w_scheduler #(
    parameter  int NoSlvPorts = 4,
    parameter  int MaxWTrans  = 8,
    localparam int IdxWidth   = $clog2(NoSlvPorts)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    axi_mux_aw_w_scheduler_if.master     io_bus,
    output logic [$clog2(MaxWTrans):0]   w_usage_o
);
    localparam int PtrWidth = $clog2(MaxWTrans);

    typedef enum logic {IDLE, LOCKED} awState_e;

    awState_e            r_state;
    awState_e            w_nextState;
    logic [IdxWidth-1:0] r_rrPtr;
    logic [IdxWidth-1:0] r_lockIdx;
    logic [IdxWidth-1:0] r_fifo [MaxWTrans];
    logic [PtrWidth-1:0] r_wrPtr;
    logic [PtrWidth-1:0] r_rdPtr;
    logic [PtrWidth:0]   r_usage;

    logic                w_full;
    logic                w_empty;
    logic [IdxWidth:0]   w_candidate;
    logic                w_arbFound;
    logic [IdxWidth-1:0] w_arbIdx;
    logic                w_grantValid;
    logic [IdxWidth-1:0] w_grantIdx;
    logic                w_awValid;
    logic                w_awHs;
    logic                w_fallThrough;
    logic                w_wActive;
    logic [IdxWidth-1:0] w_wIdx;
    logic                w_wValid;
    logic                w_wLast;
    logic                w_push;
    logic                w_pop;

    assign w_full    = (r_usage == (PtrWidth+1)'(MaxWTrans));
    assign w_empty   = (r_usage == '0);
    assign w_usage_o = r_usage;

    // Search starts at the round-robin pointer and wraps, so the first hit is the fair winner.
    always_comb begin
        w_arbFound  = 1'b0;
        w_arbIdx    = '0;
        w_candidate = '0;
        for (int i = 0; i < NoSlvPorts; i++) begin
            w_candidate = {1'b0, r_rrPtr} + (IdxWidth+1)'(i);
            if (w_candidate >= (IdxWidth+1)'(NoSlvPorts))
                w_candidate = w_candidate - (IdxWidth+1)'(NoSlvPorts);
            if (!w_arbFound && io_bus.slv_aw_valid_i[w_candidate[IdxWidth-1:0]]) begin
                w_arbFound = 1'b1;
                w_arbIdx   = w_candidate[IdxWidth-1:0];
            end
        end
    end

    always_comb begin
        w_grantValid = (r_state == LOCKED) | w_arbFound;
        w_grantIdx   = (r_state == LOCKED) ? r_lockIdx : w_arbIdx;
        w_awValid    = !rst_i & w_grantValid & !w_full;
        w_awHs       = w_awValid & io_bus.mst_aw_ready_i;
        w_nextState  = r_state;
        case (r_state)
            IDLE:    if (w_awValid && !io_bus.mst_aw_ready_i) w_nextState = LOCKED;
            LOCKED:  if (w_awHs) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        io_bus.slv_aw_ready_o = '0;
        if (w_awValid)
            io_bus.slv_aw_ready_o[w_grantIdx] = io_bus.mst_aw_ready_i;
        io_bus.mst_aw_valid_o = w_awValid;
        io_bus.mst_aw_sel_o   = w_awValid ? w_grantIdx : '0;
    end

    // With fall-through, an empty FIFO lets the AW winner drive W directly; a finished burst never enters the FIFO.
    always_comb begin
`ifdef AXI_MUX_W_FALLTHROUGH_EN
        w_fallThrough = w_empty & w_awHs;
`else
        w_fallThrough = 1'b0;
`endif
        w_wActive = !rst_i & (!w_empty | w_fallThrough);
        w_wIdx    = w_empty ? w_grantIdx : r_fifo[r_rdPtr];
        w_wValid  = w_wActive & io_bus.slv_w_valid_i[w_wIdx];
        w_wLast   = w_wValid & io_bus.mst_w_ready_i & io_bus.slv_w_last_i[w_wIdx];
        w_pop     = w_wLast & !w_empty;
        w_push    = w_awHs & !(w_fallThrough & w_wLast);
        io_bus.slv_w_ready_o = '0;
        if (w_wActive)
            io_bus.slv_w_ready_o[w_wIdx] = io_bus.mst_w_ready_i;
        io_bus.mst_w_valid_o = w_wValid;
        io_bus.mst_w_sel_o   = w_wValid ? w_wIdx : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_lockIdx <= '0;
            r_rrPtr   <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_nextState == LOCKED)
                r_lockIdx <= w_grantIdx;
            if (w_awHs)
                r_rrPtr <= (w_grantIdx == IdxWidth'(NoSlvPorts-1)) ? '0 : w_grantIdx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_usage <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            if (w_push && !w_pop)      r_usage <= r_usage + 1'b1;
            else if (w_pop && !w_push) r_usage <= r_usage - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_fifo[r_wrPtr] <= w_grantIdx;
    end
endmodule
